// File: rtl/chrono_lap_core.sv
// -----------------------------------------------------------------------------
// chrono_lap_core
//
// Timekeeping stage of the start/stop chronometer. A prescaler divides clk_ms
// down to a 100 Hz tick. Each tick advances a BCD time count MM:SS.cc. A lap
// register can freeze the displayed value while the live count keeps running.
//
// Optional feature macro: CHRONO_OVERFLOW_FLAG_EN
//   defined   : overflow is a sticky flag. It is set on the 59:59.99 -> 00:00.00
//               wrap tick and cleared by a clear while stopped, or by reset.
//   undefined : overflow is tied to 0 and no flag register exists.
//
// Parameters:
//   TICK_DIV  clk_ms cycles per centisecond tick (>= 2)
//   CNT_W     prescaler width, 2**CNT_W > TICK_DIV
//
// Ports:
//   clk_ms      in   master clock, all logic on posedge
//   reset_n     in   asynchronous active-low reset
//   run         in   1 = counting, 0 = stopped (toggle flip-flop level)
//   clr_in      in   clear button monostable (level, acted on at rising edge)
//   lap_in      in   lap button monostable (level, acted on at rising edge)
//   disp        out  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, BCD
//   running     out  registered copy of run
//   lap_active  out  1 = disp shows the frozen lap value
//   overflow    out  sticky wrap flag (0 when the feature is not built)
// -----------------------------------------------------------------------------
module chrono_lap_core #(
    parameter int TICK_DIV = 250000,
    parameter int CNT_W    = 18
) (
    input  logic        clk_ms,
    input  logic        reset_n,
    input  logic        run,
    input  logic        clr_in,
    input  logic        lap_in,
    output logic [23:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

    // Adds the carry-in to one BCD digit that wraps after 'lim'.
    // Returns {carry_out, digit}. Any value at or above the limit wraps to 0,
    // so a corrupted digit can never persist as a non-BCD value.
    function automatic logic [4:0] digit_inc(input logic [3:0] d,
                                             input logic [3:0] lim,
                                             input logic       cin);
        logic [4:0] res;
        if (!cin)
            res = {1'b0, d};
        else if (d >= lim)
            res = {1'b1, 4'd0};
        else
            res = {1'b0, d + 4'd1};
        return res;
    endfunction

    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] presc_next;
    logic [23:0]      live_q;
    logic [23:0]      live_next;
    logic [23:0]      live_inc;
    logic [23:0]      lap_q;
    logic [23:0]      lap_next;
    logic             lap_active_next;
    logic             clr_in_p1;
    logic             lap_in_p1;
    logic             tick;
    logic             clr_rise;
    logic             lap_rise;
    logic             clr_go;
    logic             wrap;
    logic [6:0]       carry;

    // Input edge detection: one event per rising edge, however long the
    // monostable pulse is held high.
    assign clr_rise = clr_in & ~clr_in_p1;
    assign lap_rise = lap_in & ~lap_in_p1;

    // A clear is honoured only while stopped.
    assign clr_go = clr_rise & ~run;

    // Tick is qualified by run, so a clear and a tick can never coincide.
    assign tick = run & (presc_q == PRESC_MAX);

    // BCD ripple increment of the live time, least significant digit first.
    always_comb begin
        live_inc = live_q;
        carry    = '0;
        carry[0] = 1'b1;
        {carry[1], live_inc[3:0]}   = digit_inc(live_q[3:0],   4'd9, carry[0]);
        {carry[2], live_inc[7:4]}   = digit_inc(live_q[7:4],   4'd9, carry[1]);
        {carry[3], live_inc[11:8]}  = digit_inc(live_q[11:8],  4'd9, carry[2]);
        {carry[4], live_inc[15:12]} = digit_inc(live_q[15:12], 4'd5, carry[3]);
        {carry[5], live_inc[19:16]} = digit_inc(live_q[19:16], 4'd9, carry[4]);
        {carry[6], live_inc[23:20]} = digit_inc(live_q[23:20], 4'd5, carry[5]);
    end

    // Carry out of the minutes-tens digit marks 59:59.99 -> 00:00.00.
    assign wrap = carry[6];

    // Next-state selection. Clear (stopped only) overrides everything,
    // including a lap event in the same cycle. The lap capture reads live_q,
    // so a coincident tick stores the pre-increment value.
    always_comb begin
        presc_next      = presc_q;
        live_next       = live_q;
        lap_next        = lap_q;
        lap_active_next = lap_active;
        if (clr_go) begin
            presc_next      = '0;
            live_next       = '0;
            lap_active_next = 1'b0;
        end else begin
            // When stopped the prescaler holds, so no sub-tick time is lost.
            if (run)
                presc_next = tick ? '0 : presc_q + CNT_W'(1);
            if (tick)
                live_next = live_inc;
            if (lap_rise) begin
                if (!lap_active) begin
                    lap_next        = live_q;
                    lap_active_next = 1'b1;
                end else begin
                    lap_active_next = 1'b0;
                end
            end
        end
    end

    // Stage boundary: all state registers.
    always_ff @(posedge clk_ms or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            live_q     <= '0;
            lap_q      <= '0;
            lap_active <= 1'b0;
            running    <= 1'b0;
            clr_in_p1  <= 1'b0;
            lap_in_p1  <= 1'b0;
        end else begin
            presc_q    <= presc_next;
            live_q     <= live_next;
            lap_q      <= lap_next;
            lap_active <= lap_active_next;
            running    <= run;
            clr_in_p1  <= clr_in;
            lap_in_p1  <= lap_in;
        end
    end

`ifdef CHRONO_OVERFLOW_FLAG_EN
    logic overflow_q;

    always_ff @(posedge clk_ms or negedge reset_n) begin
        if (!reset_n)
            overflow_q <= 1'b0;
        else if (clr_go)
            overflow_q <= 1'b0;
        else if (tick && wrap)
            overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;
`else
    logic unused_wrap;

    assign unused_wrap = wrap;
    assign overflow    = 1'b0;
`endif

    // The display is a plain mux of registers and adds no latency.
    assign disp = lap_active ? lap_q : live_q;

endmodule
